// File: rtl/tlb_cache.sv
// tlb_cache: fully-associative TLB in front of a page-table walker.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   flush               invalidate every entry at the clock edge
//   lookup_*            CPU lookup request (valid/vaddr) and ready
//   resp_*              one-cycle response strobe with paddr, hit and fault flags
//   translate_request   walk request to the walker, walk_vaddr is its address
//   translation_done    walker completion, fault qualifies it
//   tlb_update_*        walker fill strobe with virtual/physical address
//   hit_count           wrapping count of TLB hits
//   miss_count          wrapping count of walks launched
module tlb_cache #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_vaddr,
    output logic        lookup_ready,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_hit,
    output logic        resp_fault,
    output logic        translate_request,
    output logic [31:0] walk_vaddr,
    input  logic        translation_done,
    input  logic        fault,
    input  logic        tlb_update_valid,
    input  logic [31:0] tlb_update_vaddr,
    input  logic [31:0] tlb_update_paddr,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IW = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RELEASE} state_t;

    state_t             state, next_state;
    logic [ENTRIES-1:0] valid;
    logic [19:0]        vpn [ENTRIES];
    logic [19:0]        ppn [ENTRIES];
    logic [IW-1:0]      rr_ptr, victim, match_idx, free_idx;
    logic               any_match, any_free, hit, fill_ok;
    logic [19:0]        hit_ppn;
    logic [31:0]        vaddr_q;
    logic               unused;

    assign lookup_ready = state == IDLE;
    assign walk_vaddr   = vaddr_q;
    // A walk only fills when the walker presents a clean, non-faulting update.
    assign fill_ok      = !fault && tlb_update_valid;
    // Same-VPN entry is refreshed in place; otherwise lowest free slot, else round-robin.
    assign victim       = any_match ? match_idx : any_free ? free_idx : rr_ptr;
    assign unused       = ^tlb_update_vaddr[11:0];

    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (valid[i] && vpn[i] == vaddr_q[31:12]) begin
                hit     = 1'b1;
                hit_ppn = ppn[i];
            end
    end

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (valid[i] && vpn[i] == tlb_update_vaddr[31:12]) begin
                any_match = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = lookup_valid ? LOOKUP : IDLE;
            LOOKUP:  next_state = (hit && !flush) ? IDLE : WALK;
            WALK:    next_state = translation_done ? RELEASE : WALK;
            RELEASE: next_state = translation_done ? RELEASE : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid             <= '0;
            rr_ptr            <= '0;
            vaddr_q           <= '0;
            resp_valid        <= 1'b0;
            resp_paddr        <= '0;
            resp_hit          <= 1'b0;
            resp_fault        <= 1'b0;
            translate_request <= 1'b0;
            hit_count         <= '0;
            miss_count        <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn[i] <= '0;
                ppn[i] <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            if (state == IDLE && lookup_valid)
                vaddr_q <= lookup_vaddr;
            if (state == LOOKUP) begin
                if (hit && !flush) begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_paddr <= {hit_ppn, vaddr_q[11:0]};
                    hit_count  <= hit_count + 16'd1;
                end else begin
                    translate_request <= 1'b1;
                    miss_count        <= miss_count + 16'd1;
                end
            end
            if (state == WALK && translation_done) begin
                translate_request <= 1'b0;
                resp_valid        <= 1'b1;
                resp_hit          <= 1'b0;
                resp_fault        <= !fill_ok;
                resp_paddr        <= fill_ok ? tlb_update_paddr : 32'd0;
                if (fill_ok) begin
                    valid[victim] <= 1'b1;
                    vpn[victim]   <= tlb_update_vaddr[31:12];
                    ppn[victim]   <= tlb_update_paddr[31:12];
                    if (!any_match && !any_free)
                        rr_ptr <= rr_ptr + IW'(1);
                end
            end
            // Placed last so a flush overrides a fill on the same edge.
            if (flush) begin
                valid  <= '0;
                rr_ptr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: table-driven bench for tlb_cache with a scripted walker.
module tb_tlb_cache;
    logic        clk = 0, reset = 1, flush = 0;
    logic        lookup_valid = 0;
    logic [31:0] lookup_vaddr = 0;
    logic        lookup_ready, resp_valid, resp_hit, resp_fault, translate_request;
    logic [31:0] resp_paddr, walk_vaddr;
    logic        translation_done = 0, fault = 0, tlb_update_valid = 0;
    logic [31:0] tlb_update_vaddr = 0, tlb_update_paddr = 0;
    logic [15:0] hit_count, miss_count;

    tlb_cache #(.ENTRIES(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_vaddr(lookup_vaddr), .lookup_ready(lookup_ready),
        .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_hit(resp_hit), .resp_fault(resp_fault),
        .translate_request(translate_request), .walk_vaddr(walk_vaddr),
        .translation_done(translation_done), .fault(fault),
        .tlb_update_valid(tlb_update_valid), .tlb_update_vaddr(tlb_update_vaddr),
        .tlb_update_paddr(tlb_update_paddr), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // f: 0 clean fill, 1 walker fault, 2 done without update (protocol error)
    // fm: 0 no flush, 1 flush before lookup, 2 flush in LOOKUP, 3 flush on fill edge
    typedef struct {
        logic [31:0] va;
        int          f;
        logic [31:0] pa;
        int          hold;
        int          fm;
        bit          eh;
        logic [31:0] epa;
        bit          ef;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0, fails = 0;
    int   exp_h = 0, exp_m = 0;

    function automatic void check(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    task automatic run(input vec_t v, output logic h, output logic [31:0] pa,
                       output logic flt, output int lat, output int walks);
        lat = 0; walks = 0;
        if (v.fm == 1) begin
            @(negedge clk); flush = 1;
            @(negedge clk); flush = 0;
        end
        @(negedge clk);
        lookup_valid = 1; lookup_vaddr = v.va;
        @(negedge clk);
        lookup_valid = 0; lat = 1;
        if (v.fm == 2) flush = 1;
        while (!resp_valid && lat < 40) begin
            if (translate_request && !translation_done) begin
                walks++;
                check($sformatf("walk_vaddr %h", v.va), walk_vaddr, v.va);
                translation_done = 1;
                fault            = v.f == 1;
                tlb_update_valid = v.f == 0;
                tlb_update_vaddr = v.va;
                tlb_update_paddr = v.pa;
                if (v.fm == 3) flush = 1;
            end
            @(negedge clk);
            lat++;
            flush = 0;
        end
        check($sformatf("resp_valid %h", v.va), {31'd0, resp_valid}, 32'd1);
        h = resp_hit; pa = resp_paddr; flt = resp_fault;
        if (translation_done) begin
            for (int i = 1; i < v.hold; i++) begin
                tlb_update_vaddr = 32'h0060_0000;
                tlb_update_paddr = 32'h0088_8000;
                check($sformatf("release_busy %0d", i), {31'd0, lookup_ready}, 32'd0);
                @(negedge clk);
            end
            translation_done = 0; fault = 0; tlb_update_valid = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        h, flt;
        logic [31:0] pa;
        int          lat, walks;
        vec_t        v;
        tbl.push_back('{32'h0040_1ABC, 0, 32'h0009_3ABC, 1, 0, 1'b0, 32'h0009_3ABC, 1'b0});
        tbl.push_back('{32'h0040_1FFF, 0, 32'h0,         1, 0, 1'b1, 32'h0009_3FFF, 1'b0});
        tbl.push_back('{32'h8000_0000, 1, 32'h0,         1, 0, 1'b0, 32'h0,         1'b1});
        tbl.push_back('{32'h8000_0000, 0, 32'h0000_5000, 1, 0, 1'b0, 32'h0000_5000, 1'b0});
        tbl.push_back('{32'h8000_0004, 0, 32'h0,         1, 0, 1'b1, 32'h0000_5004, 1'b0});
        tbl.push_back('{32'h0090_0000, 2, 32'h0,         1, 0, 1'b0, 32'h0,         1'b1});
        tbl.push_back('{32'h0090_0000, 0, 32'h0011_1000, 1, 0, 1'b0, 32'h0011_1000, 1'b0});
        for (int k = 0; k < 9; k++)
            tbl.push_back('{32'h1000_0000 + (32'(k) << 12), 0, 32'h2000_0000 + (32'(k) << 12),
                            1, (k == 0) ? 1 : 0, 1'b0, 32'h2000_0000 + (32'(k) << 12), 1'b0});
        tbl.push_back('{32'h1000_0000, 0, 32'h2100_0000, 1, 0, 1'b0, 32'h2100_0000, 1'b0});
        tbl.push_back('{32'h1000_2010, 0, 32'h0,         1, 0, 1'b1, 32'h2000_2010, 1'b0});
        tbl.push_back('{32'h1000_8FFF, 0, 32'h0,         1, 0, 1'b1, 32'h2000_8FFF, 1'b0});
        tbl.push_back('{32'h1000_1000, 0, 32'h2100_1000, 1, 0, 1'b0, 32'h2100_1000, 1'b0});
        tbl.push_back('{32'h1000_2000, 0, 32'h2100_2000, 1, 0, 1'b0, 32'h2100_2000, 1'b0});
        tbl.push_back('{32'h1000_4000, 0, 32'h0,         1, 0, 1'b1, 32'h2000_4000, 1'b0});
        tbl.push_back('{32'h1000_3000, 0, 32'h2100_3000, 1, 0, 1'b0, 32'h2100_3000, 1'b0});
        tbl.push_back('{32'h0050_0123, 0, 32'h0077_7123, 5, 1, 1'b0, 32'h0077_7123, 1'b0});
        tbl.push_back('{32'h0050_0FFF, 0, 32'h0,         1, 0, 1'b1, 32'h0077_7FFF, 1'b0});
        tbl.push_back('{32'h0060_0000, 0, 32'h0099_9000, 1, 0, 1'b0, 32'h0099_9000, 1'b0});
        tbl.push_back('{32'h0070_0456, 0, 32'h00AA_A456, 1, 3, 1'b0, 32'h00AA_A456, 1'b0});
        tbl.push_back('{32'h0070_0456, 0, 32'h00BB_B456, 1, 0, 1'b0, 32'h00BB_B456, 1'b0});
        tbl.push_back('{32'h0050_0000, 0, 32'h0077_7000, 1, 0, 1'b0, 32'h0077_7000, 1'b0});
        tbl.push_back('{32'h0070_0000, 0, 32'h00CC_C000, 1, 2, 1'b0, 32'h00CC_C000, 1'b0});
        tbl.push_back('{32'h0050_0000, 0, 32'h0077_7000, 1, 0, 1'b0, 32'h0077_7000, 1'b0});
        tbl.push_back('{32'h0070_0ABC, 0, 32'h0,         1, 0, 1'b1, 32'h00CC_CABC, 1'b0});

        #1;
        check("reset lookup_ready", {31'd0, lookup_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset translate_request", {31'd0, translate_request}, 32'd0);
        check("reset counts", {hit_count, miss_count}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;

        foreach (tbl[i]) begin
            run(tbl[i], h, pa, flt, lat, walks);
            check($sformatf("row%0d hit", i), {31'd0, h}, {31'd0, tbl[i].eh});
            check($sformatf("row%0d paddr", i), pa, tbl[i].epa);
            check($sformatf("row%0d fault", i), {31'd0, flt}, {31'd0, tbl[i].ef});
            check($sformatf("row%0d walks", i), walks, tbl[i].eh ? 0 : 1);
            if (tbl[i].eh) begin
                check($sformatf("row%0d latency", i), lat, 2);
                exp_h++;
            end else
                exp_m++;
        end
        check("hit_count", {16'd0, hit_count}, exp_h);
        check("miss_count", {16'd0, miss_count}, exp_m);

        @(negedge clk);
        lookup_valid = 1; lookup_vaddr = 32'h0123_4000;
        @(negedge clk);
        lookup_valid = 0;
        @(negedge clk);
        check("walk started", {31'd0, translate_request}, 32'd1);
        #2 reset = 1;
        #1;
        check("midwalk reset translate_request", {31'd0, translate_request}, 32'd0);
        check("midwalk reset lookup_ready", {31'd0, lookup_ready}, 32'd1);
        check("midwalk reset counts", {hit_count, miss_count}, 32'd0);
        @(negedge clk);
        reset = 0;
        v = '{32'h0070_0ABC, 0, 32'h00DD_DABC, 1, 0, 1'b0, 32'h00DD_DABC, 1'b0};
        run(v, h, pa, flt, lat, walks);
        check("post reset hit", {31'd0, h}, 32'd0);
        check("post reset paddr", pa, 32'h00DD_DABC);
        check("post reset miss_count", {16'd0, miss_count}, 32'd1);
        check("post reset hit_count", {16'd0, hit_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
